// File: rtl/bridge_timer_if.sv
// Bridge-side bus of the countdown timer: word select, write strobe and data,
// combinational read data and the interrupt line back to the CPU.
interface bridge_timer_if;
  logic [1:0]  Addr;
  logic        WE;
  logic [31:0] DIN;
  logic [31:0] DOUT;
  logic        IRQ;

  modport master (output Addr, output WE, output DIN, input DOUT, input IRQ);
  modport slave  (input Addr, input WE, input DIN, output DOUT, output IRQ);
endinterface

// File: rtl/bridge_timer.sv
// Memory-mapped countdown timer: CTRL / PRESET / COUNT registers, one-shot and
// auto-reload modes, masked interrupt. Bus writes to CTRL/PRESET override the
// counting FSM on the same edge and send it back to IDLE.
module bridge_timer #(
  parameter int CTRL_W = 4
) (
  input  logic           clk,
  input  logic           reset,
  bridge_timer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  state_t              state, state_next;
  logic [CTRL_W-1:0]   ctrl_reg, ctrl_next;
  logic [31:0]         preset_reg, preset_next;
  logic [31:0]         count_reg, count_next;
  logic                irq_flag, irq_next;

  logic en, im, auto_reload, cfg_write;

  assign en          = ctrl_reg[0];
  assign im          = ctrl_reg[3];
  // Only MODE = 01 reloads; 10 and 11 fall back to one-shot.
  assign auto_reload = (ctrl_reg[2:1] == 2'b01);
  assign cfg_write   = bus.WE && (bus.Addr == 2'd0 || bus.Addr == 2'd1);

  // Interrupt comes purely from registered state.
  assign bus.IRQ = im & irq_flag;

  // Zero-latency read mux; reading never has side effects.
  always_comb begin
    bus.DOUT = 32'd0;
    case (bus.Addr)
      2'd0:    bus.DOUT = 32'(ctrl_reg);
      2'd1:    bus.DOUT = preset_reg;
      2'd2:    bus.DOUT = count_reg;
      default: bus.DOUT = 32'd0;
    endcase
  end

  // State register for FSM and all software-visible registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      ctrl_reg   <= '0;
      preset_reg <= 32'd0;
      count_reg  <= 32'd0;
      irq_flag   <= 1'b0;
    end else begin
      state      <= state_next;
      ctrl_reg   <= ctrl_next;
      preset_reg <= preset_next;
      count_reg  <= count_next;
      irq_flag   <= irq_next;
    end
  end

  // Next-state logic: FSM step first, then a CTRL/PRESET write discards it.
  always_comb begin
    state_next  = state;
    ctrl_next   = ctrl_reg;
    preset_next = preset_reg;
    count_next  = count_reg;
    irq_next    = irq_flag;

    case (state)
      IDLE: begin
        if (en) state_next = LOAD;
      end
      LOAD: begin
        count_next = preset_reg;
        state_next = CNT;
      end
      CNT: begin
        if (!en) begin
          state_next = IDLE;
        end else if (count_reg > 32'd1) begin
          count_next = count_reg - 32'd1;
        end else begin
          // PRESET of 0 lands here too, so COUNT never wraps.
          count_next = 32'd0;
          irq_next   = 1'b1;
          state_next = INT;
        end
      end
      INT: begin
        if (auto_reload) begin
          // Flag lasts one cycle; EN stays set so the timer reloads.
          irq_next = 1'b0;
        end else begin
          // One-shot stops itself; flag holds until software rewrites.
          ctrl_next[0] = 1'b0;
        end
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (cfg_write) begin
      ctrl_next   = ctrl_reg;
      count_next  = count_reg;
      irq_next    = 1'b0;
      state_next  = IDLE;
      if (bus.Addr == 2'd0)
        ctrl_next = bus.DIN[CTRL_W-1:0];
      else
        preset_next = bus.DIN;
    end
  end

endmodule

// File: tb/tb_bridge_timer.sv
// Directed bench for bridge_timer: reset, one-shot, auto-reload, masking,
// pause/resume, write collision and asynchronous reset.
module tb_bridge_timer;
  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  bridge_timer_if bus ();

  bridge_timer #(.CTRL_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("vec %0d %s observed=%h expected=%h", vectors, tag, obs, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.Addr = a;
    bus.DIN  = d;
    bus.WE   = 1'b1;
    tick();
    bus.WE   = 1'b0;
    bus.DIN  = 32'd0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.Addr = a;
    #1;
    d = bus.DOUT;
  endtask

  logic [31:0] v;
  logic [1:0]  st;

  initial begin
    bus.Addr = 2'd0;
    bus.WE   = 1'b0;
    bus.DIN  = 32'd0;
    reset    = 1'b0;
    repeat (3) tick();
    reset = 1'b1;

    // Reset values and reads of every address.
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), v);
      chk($sformatf("reset_read_a%0d", a), v, 32'd0);
    end
    chk("reset_irq", 32'(bus.IRQ), 32'd0);

    // One-shot, PRESET = 3.
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h9);
    for (int k = 1; k <= 5; k++) begin
      tick();
      rd(2'd2, v);
      chk($sformatf("oneshot_count_e%0d", k), v, (k == 1) ? 32'd0 : 32'(5 - k));
      chk($sformatf("oneshot_irq_e%0d", k), 32'(bus.IRQ), (k == 5) ? 32'd1 : 32'd0);
    end
    tick();
    rd(2'd0, v);
    chk("oneshot_ctrl_after", v, 32'h8);
    repeat (3) tick();
    chk("oneshot_irq_held", 32'(bus.IRQ), 32'd1);
    wr(2'd0, 32'h0);
    chk("oneshot_irq_cleared", 32'(bus.IRQ), 32'd0);

    // Auto-reload, PRESET = 2: pulse every 5 edges.
    wr(2'd1, 32'd2);
    wr(2'd0, 32'hB);
    for (int k = 1; k <= 20; k++) begin
      tick();
      rd(2'd2, v);
      chk($sformatf("reload_irq_e%0d", k), 32'(bus.IRQ), (k % 5 == 4) ? 32'd1 : 32'd0);
      if (k % 5 == 2) chk($sformatf("reload_count_e%0d", k), v, 32'd2);
    end
    rd(2'd0, v);
    chk("reload_ctrl_en", v, 32'hB);
    wr(2'd0, 32'h0);

    // Masked one-shot, PRESET = 1.
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h1);
    repeat (10) tick();
    chk("mask_irq", 32'(bus.IRQ), 32'd0);
    chk("mask_flag", 32'(dut.irq_flag), 32'd1);
    rd(2'd2, v);
    chk("mask_count", v, 32'd0);
    rd(2'd0, v);
    chk("mask_ctrl", v, 32'h0);
    wr(2'd2, 32'h55);
    rd(2'd2, v);
    chk("count_write_ignored", v, 32'd0);
    chk("count_write_no_side", 32'(dut.irq_flag), 32'd1);
    wr(2'd0, 32'h8);
    chk("mask_set_clears_flag", 32'(bus.IRQ), 32'd0);
    wr(2'd0, 32'h0);

    // Pause and resume, PRESET = 10.
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h9);
    repeat (5) tick();
    rd(2'd2, v);
    chk("pause_count_start", v, 32'd7);
    wr(2'd0, 32'h8);
    for (int k = 1; k <= 5; k++) begin
      tick();
      rd(2'd2, v);
      chk($sformatf("pause_hold_e%0d", k), v, 32'd7);
    end
    wr(2'd0, 32'h9);
    for (int k = 1; k <= 12; k++) begin
      tick();
      rd(2'd2, v);
      if (k == 2) chk("resume_reload", v, 32'd10);
      if (k >= 11) chk($sformatf("resume_irq_e%0d", k), 32'(bus.IRQ), (k == 12) ? 32'd1 : 32'd0);
    end
    wr(2'd0, 32'h0);

    // Write collision: PRESET write on the edge that would enter INT.
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h9);
    repeat (3) tick();
    wr(2'd1, 32'd5);
    rd(2'd2, v);
    chk("collide_count", v, 32'd1);
    chk("collide_irq", 32'(bus.IRQ), 32'd0);
    st = dut.state;
    chk("collide_state", 32'(st), 32'd0);
    tick();
    tick();
    rd(2'd2, v);
    chk("collide_restart", v, 32'd5);
    tick();
    rd(2'd2, v);
    chk("collide_count_down", v, 32'd4);

    // Asynchronous reset between edges.
    reset = 1'b0;
    rd(2'd2, v);
    chk("async_count", v, 32'd0);
    chk("async_irq", 32'(bus.IRQ), 32'd0);
    rd(2'd0, v);
    chk("async_ctrl", v, 32'd0);
    reset = 1'b1;
    repeat (4) tick();
    rd(2'd2, v);
    chk("async_no_resume", v, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
